tx_arbiter: RTL and testbench
=============================

# tx_arbiter

Round-robin scheduler that shares one UART transmit engine between four byte requesters. It picks a winner among pending requests and presents that byte on the engine's parallel input with a one-cycle load strobe. It then waits for the engine to report completion before granting again, and flags an error if completion never arrives. It sits between the TX-side producers (command echo, status reporter, etc.) and the transmit engine's OUT_PORT/LOAD/TXRDY pins.

## Interface
- TIMEOUT, 4000000: WAIT-state cycle limit before declaring the engine hung. Exceeds 11 bits at the slowest baud setting.
- TO_W, 22: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- REQ  in  4  per-requester request level; bit i = requester i has a byte pending
- DATA  in  32  requester bytes; requester i uses DATA[8i+7:8i]
- ACK  out  4  one-cycle pulse on bit i when requester i's byte is taken
- OUT_PORT  out  8  byte to engine; registered, stable from LOAD until next grant
- LOAD  out  1  one-cycle load strobe to engine
- TXRDY  in  1  engine ready/done flag; level, high after a frame completes
- GRANT_ID  out  2  index of most recently granted requester
- BUSY  out  1  high while a frame is in flight (states SEND, WAIT)
- ERR  out  1  sticky timeout flag
- CLR_ERR  in  1  synchronous clear of ERR

## Operation
- Internal flag eng_free, reset value 1. The engine's TXRDY resets low and only rises after the first frame, so the controller does not wait on TXRDY after reset.
- TXRDY is registered into txrdy_q (reset 0). rise = TXRDY & ~txrdy_q.
- Round-robin pointer last (2 bits, reset 3). Search order is last+1, last+2, last+3, last (mod 4). The first set REQ bit wins. Because the pointer resets to 3, requester 0 is first in order after reset.
- State IDLE:
  - If eng_free & |REQ, then at the next edge: go to SEND, OUT_PORT<=winner's byte, GRANT_ID<=winner, last<=winner, LOAD<=1, ACK[winner]<=1.
  - Otherwise stay in IDLE.
- State SEND (one cycle): LOAD=1 and ACK pulse are visible. eng_free<=0. Go to WAIT. The timeout counter clears to 0.
- State WAIT:
  - Counter increments each cycle.
  - If rise: eng_free<=1, go to IDLE.
  - Else if counter==TIMEOUT: ERR<=1, eng_free<=1, go to IDLE. The frame is abandoned and not retried.
- REQ changes during SEND/WAIT are ignored until IDLE.
- A requester must hold REQ and its DATA stable until it sees ACK. If REQ is still high the cycle after ACK, it is treated as a new byte. The requester drops REQ or updates DATA in the ACK cycle.
- ERR: set on timeout, cleared by CLR_ERR. If both occur in the same cycle, set wins. ERR does not block arbitration.
- Reset values: LOAD 0, ACK 0000, OUT_PORT 00, GRANT_ID 0, BUSY 0, ERR 0. State IDLE, last 3, counter 0.

## Timing
- Grant latency: REQ seen high in IDLE at edge N gives LOAD and ACK high during cycle N+1, for exactly one cycle.
- OUT_PORT is valid in the same cycle as LOAD and holds until the next grant.
- Back-to-back: TXRDY rise sampled at edge M leads to IDLE at M+1, and the next LOAD is at cycle M+2 at the earliest.
- Stale TXRDY handling: TXRDY may still be high for one or two cycles after LOAD, left over from the previous frame. This produces no rise, because txrdy_q is already 1.
- Rise and timeout in the same cycle: rise wins, and ERR is not set.
- RESET asserted mid-frame: all outputs go to reset values immediately (asynchronously). The next grant requires no TXRDY.
- BUSY = state is SEND or WAIT. It is combinational from the state register.

## Test plan
- Reset, then REQ=0001, DATA[7:0]=8'hA5 → LOAD=1 and ACK=0001 one cycle later, OUT_PORT=A5, GRANT_ID=0, BUSY=1. Checks that no TXRDY is needed for the first grant.
- REQ=1111 held, with TXRDY pulsed high 20 cycles after each LOAD → grant order 0,1,2,3,0. Exactly one LOAD per TXRDY rise, and the gap from rise to LOAD is 2 cycles.
- TXRDY held high continuously from the previous frame across a new LOAD → no second grant until TXRDY falls and rises again.
- TIMEOUT=50, single request, TXRDY stuck low → ERR=1 in the cycle after counter hits 50 and state returns to IDLE. The next REQ is granted. CLR_ERR=1 clears ERR; CLR_ERR asserted together with a timeout leaves ERR=1.
- REQ=0100 granted, then REQ=0010 asserted during WAIT → ignored until the TXRDY rise, then granted (GRANT_ID=1) two cycles later.
- RESET pulsed during WAIT → LOAD/ACK/BUSY/ERR go to 0 immediately. After release, a pending REQ=1000 is granted without any TXRDY.

Source files
------------

// File: rtl/tx_arbiter_if.sv
// Requester/engine-side signal bundle for the UART transmit arbiter.
// slave = arbiter view, master = producers + transmit engine view.
interface tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [7:0]  out_port;
  logic        load;
  logic        txrdy;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;
  logic        clr_err;

  modport slave (
    input  req, data, txrdy, clr_err,
    output ack, out_port, load, grant_id, busy, err
  );

  modport master (
    output req, data, txrdy, clr_err,
    input  ack, out_port, load, grant_id, busy, err
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin scheduler sharing one UART transmit engine between four byte
// requesters; grants one byte per engine completion and flags a hung engine.
module tx_arbiter #(
  parameter int unsigned TIMEOUT = 4000000,
  parameter int unsigned TO_W    = 22
) (
  input  logic        clk_i,
  input  logic        rst_i,
  tx_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_e;

  state_e          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      grant_q, grant_d;
  logic [7:0]      out_q, out_d;
  logic            load_q, load_d;
  logic [3:0]      ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            eng_free_q, eng_free_d;
  logic            txrdy_q;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            found;
  logic            rise;

  assign rise = bus_io.txrdy & ~txrdy_q;

  // First pending requester after the last winner, wrapping back to it last.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus_io.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    out_d      = out_q;
    load_d     = 1'b0;
    ack_d      = 4'b0000;
    eng_free_d = eng_free_q;
    cnt_d      = cnt_q;
    err_d      = bus_io.clr_err ? 1'b0 : err_q;

    case (state_q)
      ST_IDLE: begin
        if (eng_free_q && found) begin
          state_d = ST_SEND;
          out_d   = bus_io.data[{winner, 3'b000} +: 8];
          grant_d = winner;
          last_d  = winner;
          load_d  = 1'b1;
          ack_d   = 4'b0001 << winner;
        end
      end
      ST_SEND: begin
        eng_free_d = 1'b0;
        cnt_d      = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        // A completion edge beats a simultaneous timeout.
        if (rise) begin
          eng_free_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == TO_W'(TIMEOUT)) begin
          err_d      = 1'b1;
          eng_free_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      last_q     <= 2'd3;
      grant_q    <= 2'd0;
      out_q      <= 8'h00;
      load_q     <= 1'b0;
      ack_q      <= 4'b0000;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      eng_free_q <= 1'b1;
      txrdy_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      out_q      <= out_d;
      load_q     <= load_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      eng_free_q <= eng_free_d;
      txrdy_q    <= bus_io.txrdy;
      cnt_q      <= cnt_d;
    end
  end

  assign bus_io.out_port = out_q;
  assign bus_io.load     = load_q;
  assign bus_io.ack      = ack_q;
  assign bus_io.grant_id = grant_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.err      = err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: reset, first grant, round-robin order,
// stale TXRDY, timeout/ERR, requests during WAIT and mid-frame reset.
module tb_tx_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   extra;
  logic [31:0] dat;
  logic [7:0]  exp_byte;

  tx_arbiter_if bus ();

  tx_arbiter #(.TIMEOUT(50), .TO_W(6)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completes a frame already in WAIT by producing one clean TXRDY rise.
  task automatic finish_frame();
    bus.txrdy = 1'b0;
    tick();
    bus.txrdy = 1'b1;
    tick();
    bus.txrdy = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.req     = 4'b0000;
    bus.data    = 32'h0;
    bus.txrdy   = 1'b0;
    bus.clr_err = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.load, bus.ack, bus.out_port, bus.grant_id, bus.busy, bus.err} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: load=%b ack=%b out=%h gid=%0d busy=%b err=%b, want all zero",
               bus.load, bus.ack, bus.out_port, bus.grant_id, bus.busy, bus.err);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus.load, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle_no_req: load=%b busy=%b, want 0 0", bus.load, bus.busy);
    end
  endtask

  task automatic test_first_grant();
    bus.data = 32'h0000_00A5;
    bus.req  = 4'b0001;
    tick();
    n_checks++;
    if ({bus.load, bus.ack, bus.out_port, bus.grant_id, bus.busy} !== {1'b1, 4'b0001, 8'hA5, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL first_grant: load=%b ack=%b out=%h gid=%0d busy=%b, want 1 0001 a5 0 1",
               bus.load, bus.ack, bus.out_port, bus.grant_id, bus.busy);
    end
    bus.req = 4'b0000;
    tick();
    n_checks++;
    if ({bus.load, bus.ack, bus.out_port, bus.busy} !== {1'b0, 4'b0000, 8'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL first_pulse_width: load=%b ack=%b out=%h busy=%b, want 0 0000 a5 1",
               bus.load, bus.ack, bus.out_port, bus.busy);
    end
    bus.txrdy = 1'b1;
    tick();
    bus.txrdy = 1'b0;
    n_checks++;
    if ({bus.busy, bus.load} !== 2'b00) begin
      n_fail++;
      $display("FAIL first_done: busy=%b load=%b, want 0 0", bus.busy, bus.load);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5];
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
    apply_reset();
    dat      = 32'hD3C2_B1A0;
    bus.data = dat;
    bus.req  = 4'b1111;
    tick();
    n_checks++;
    if ({bus.load, bus.grant_id, bus.ack, bus.out_port} !== {1'b1, 2'd0, 4'b0001, 8'hA0}) begin
      n_fail++;
      $display("FAIL rr_grant0: load=%b gid=%0d ack=%b out=%h, want 1 0 0001 a0",
               bus.load, bus.grant_id, bus.ack, bus.out_port);
    end
    for (int g = 1; g < 5; g++) begin
      extra = 0;
      for (int c = 0; c < 19; c++) begin
        tick();
        if (bus.load) extra++;
      end
      bus.txrdy = 1'b1;
      tick();
      bus.txrdy = 1'b0;
      if (bus.load) extra++;
      tick();
      exp_byte = dat[8*int'(exp_id[g]) +: 8];
      n_checks++;
      if ({bus.load, bus.grant_id, bus.ack, bus.out_port} !==
          {1'b1, exp_id[g], 4'b0001 << exp_id[g], exp_byte}) begin
        n_fail++;
        $display("FAIL rr_grant%0d: load=%b gid=%0d ack=%b out=%h, want 1 %0d %b %h", g,
                 bus.load, bus.grant_id, bus.ack, bus.out_port, exp_id[g], 4'b0001 << exp_id[g], exp_byte);
      end
      n_checks++;
      if (extra != 0) begin
        n_fail++;
        $display("FAIL rr_extra_load%0d: got %0d stray LOADs, want 0", g, extra);
      end
    end
    bus.req = 4'b0000;
    tick();
    finish_frame();
  endtask

  task automatic test_stale_txrdy();
    bus.req = 4'b0010;
    tick();
    n_checks++;
    if ({bus.load, bus.grant_id} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL stale_setup_grant: load=%b gid=%0d, want 1 1", bus.load, bus.grant_id);
    end
    bus.req = 4'b0000;
    tick();
    bus.txrdy = 1'b1;
    tick();
    bus.req = 4'b0100;
    tick();
    n_checks++;
    if ({bus.load, bus.grant_id, bus.out_port} !== {1'b1, 2'd2, 8'hC2}) begin
      n_fail++;
      $display("FAIL stale_grant2: load=%b gid=%0d out=%h, want 1 2 c2",
               bus.load, bus.grant_id, bus.out_port);
    end
    bus.req = 4'b1000;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.load) extra++;
    end
    n_checks++;
    if (extra != 0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stale_no_regrant: loads=%0d busy=%b, want 0 1", extra, bus.busy);
    end
    bus.txrdy = 1'b0;
    tick();
    n_checks++;
    if ({bus.busy, bus.load} !== 2'b10) begin
      n_fail++;
      $display("FAIL stale_fall: busy=%b load=%b, want 1 0", bus.busy, bus.load);
    end
    bus.txrdy = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({bus.load, bus.grant_id, bus.ack} !== {1'b1, 2'd3, 4'b1000}) begin
      n_fail++;
      $display("FAIL stale_regrant: load=%b gid=%0d ack=%b, want 1 3 1000",
               bus.load, bus.grant_id, bus.ack);
    end
    bus.req = 4'b0000;
    tick();
    finish_frame();
  endtask

  task automatic test_timeout();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    for (int c = 0; c < 51; c++) tick();
    n_checks++;
    if ({bus.busy, bus.err} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_early: busy=%b err=%b, want 1 0", bus.busy, bus.err);
    end
    tick();
    n_checks++;
    if ({bus.busy, bus.err} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_fire: busy=%b err=%b, want 0 1", bus.busy, bus.err);
    end
    bus.req = 4'b0010;
    tick();
    n_checks++;
    if ({bus.load, bus.grant_id, bus.err} !== {1'b1, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_next_grant: load=%b gid=%0d err=%b, want 1 1 1",
               bus.load, bus.grant_id, bus.err);
    end
    bus.req = 4'b0000;
    tick();
    finish_frame();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: err=%b, want 0", bus.err);
    end
    bus.req = 4'b0001;
    tick();
    bus.req     = 4'b0000;
    bus.clr_err = 1'b1;
    for (int c = 0; c < 51; c++) tick();
    tick();
    n_checks++;
    if ({bus.busy, bus.err} !== 2'b01) begin
      n_fail++;
      $display("FAIL set_beats_clear: busy=%b err=%b, want 0 1", bus.busy, bus.err);
    end
    bus.clr_err = 1'b0;
    tick();
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b, want 1", bus.err);
    end
  endtask

  task automatic test_req_during_wait();
    bus.req = 4'b0100;
    tick();
    n_checks++;
    if ({bus.load, bus.grant_id} !== {1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL wait_first_grant: load=%b gid=%0d, want 1 2", bus.load, bus.grant_id);
    end
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0010;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.load) extra++;
    end
    n_checks++;
    if (extra != 0 || bus.busy !== 1'b1 || bus.grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL wait_req_ignored: loads=%0d busy=%b gid=%0d, want 0 1 2",
               extra, bus.busy, bus.grant_id);
    end
    bus.txrdy = 1'b1;
    tick();
    bus.txrdy = 1'b0;
    n_checks++;
    if ({bus.load, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL wait_rise_idle: load=%b busy=%b, want 0 0", bus.load, bus.busy);
    end
    tick();
    n_checks++;
    if ({bus.load, bus.grant_id, bus.ack, bus.out_port} !== {1'b1, 2'd1, 4'b0010, 8'hB1}) begin
      n_fail++;
      $display("FAIL wait_late_grant: load=%b gid=%0d ack=%b out=%h, want 1 1 0010 b1",
               bus.load, bus.grant_id, bus.ack, bus.out_port);
    end
    bus.req = 4'b0000;
    tick();
    finish_frame();
  endtask

  task automatic test_reset_mid_frame();
    bus.req = 4'b0001;
    tick();
    n_checks++;
    if ({bus.load, bus.busy, bus.err} !== 3'b111) begin
      n_fail++;
      $display("FAIL midrst_pre: load=%b busy=%b err=%b, want 1 1 1", bus.load, bus.busy, bus.err);
    end
    bus.req = 4'b1000;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.load, bus.ack, bus.out_port, bus.grant_id, bus.busy, bus.err} !== 17'h0) begin
      n_fail++;
      $display("FAIL midrst_async: load=%b ack=%b out=%h gid=%0d busy=%b err=%b, want all zero",
               bus.load, bus.ack, bus.out_port, bus.grant_id, bus.busy, bus.err);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus.load, bus.grant_id, bus.ack, bus.out_port} !== {1'b1, 2'd3, 4'b1000, 8'hD3}) begin
      n_fail++;
      $display("FAIL midrst_regrant: load=%b gid=%0d ack=%b out=%h, want 1 3 1000 d3",
               bus.load, bus.grant_id, bus.ack, bus.out_port);
    end
    bus.req = 4'b0000;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_first_grant();
    test_round_robin();
    test_stale_txrdy();
    test_timeout();
    test_req_during_wait();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
